router_sink: RTL and testbench

Local-port sink for the NoC router: consumes flits from one router output (TX side) under credit flow control, tags each flit as header, size or payload by tracking packet framing, and buffers tagged flits in a small FIFO. A core reads them over a valid/ready stream. It sits directly downstream of a router port and replaces the bench-side packet collector in RTL systems.

---
 rtl/router_pkg.sv | 26 ++
 rtl/flit_fifo.sv | 71 +++++++
 rtl/router_sink.sv | 137 +++++++++++++
 tb/tb_router_sink.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router types: flit width, flit tags and sink framing states.
package router_pkg;

    localparam int unsigned FLIT_WIDTH = 16;
    localparam int unsigned KIND_WIDTH = 2;

    // Tag attached to every flit by the sink framing logic.
    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        SIZE    = 2'd1,
        PAYLOAD = 2'd2
    } flit_kind_t;

    // Packet framing position of the next flit to arrive.
    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_SIZE    = 2'd1,
        S_PAYLOAD = 2'd2
    } sink_state_t;

    // Width of one buffered entry: {last, kind, data}.
    function automatic int unsigned entry_width(input int unsigned flit_w);
        return flit_w + KIND_WIDTH + 1;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Small first-word-fall-through FIFO; head is the registered entry at the read pointer.
module flit_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Guard against writes when full and reads when empty.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Storage array; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/router_sink.sv
// Router local-port sink: credit-controlled flit intake, packet framing tags,
// FWFT buffering and a valid/ready stream toward the core.
// Optional feature macro: ROUTER_SINK_ERR_EN enables the saturating drop counter.
module router_sink
    import router_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH   = router_pkg::FLIT_WIDTH,
    parameter int unsigned BUFFER_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [FLIT_WIDTH-1:0] data_in,
    output logic                  credit_o,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output flit_kind_t            flit_kind,
    output logic                  flit_last,
    output logic [15:0]           pkt_count,
    output logic [7:0]            err_count
);

    localparam int unsigned EW = entry_width(FLIT_WIDTH);

    sink_state_t           r_state;
    sink_state_t           w_state_nxt;
    logic [FLIT_WIDTH-1:0] r_remaining;
    logic [FLIT_WIDTH-1:0] w_remaining_nxt;
    flit_kind_t            w_kind;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [EW-1:0]         w_entry;
    logic [EW-1:0]         w_head;
    logic [15:0]           r_pkt_count;

    assign credit_o   = !w_full;
    assign w_accept   = rx && !w_full;
    assign flit_valid = !w_empty;
    assign w_pop      = flit_valid && flit_ready;
    assign w_entry    = {w_last, w_kind, data_in};

    assign flit_out   = w_head[FLIT_WIDTH-1:0];
    assign flit_kind  = flit_kind_t'(w_head[FLIT_WIDTH +: KIND_WIDTH]);
    assign flit_last  = w_head[EW-1];
    assign pkt_count  = r_pkt_count;

    // Framing state and remaining payload count; advance only on accepted flits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_HEADER;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    // Tag the incoming flit and compute the framing position after it.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_kind          = HEADER;
        w_last          = 1'b0;
        case (r_state)
            S_HEADER: begin
                w_kind      = HEADER;
                w_state_nxt = S_SIZE;
            end
            S_SIZE: begin
                w_kind          = SIZE;
                w_remaining_nxt = data_in;
                if (data_in == '0) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_HEADER;
                end else begin
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                w_kind          = PAYLOAD;
                w_last          = (r_remaining == FLIT_WIDTH'(1));
                w_remaining_nxt = r_remaining - FLIT_WIDTH'(1);
                if (w_last) begin
                    w_state_nxt = S_HEADER;
                end
            end
            default: begin
                w_state_nxt = S_HEADER;
            end
        endcase
    end

    // Count packets whose last flit has been taken by the core.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pkt_count <= '0;
        end else if (w_pop && flit_last) begin
            r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

`ifdef ROUTER_SINK_ERR_EN
    logic [7:0] r_err_count;

    // Saturating count of flits presented while no credit was available.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (rx && w_full && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    flit_fifo #(
        .WIDTH (EW),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_accept),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_router_sink.sv
// Directed bench for router_sink: framing tags, backpressure, back-to-back
// packets, mid-packet reset and drop handling.
module tb_router_sink;

    logic                     clock;
    logic                     reset;
    logic                     rx;
    logic [15:0]              data_in;
    logic                     credit_o;
    logic                     flit_valid;
    logic                     flit_ready;
    logic [15:0]              flit_out;
    router_pkg::flit_kind_t   flit_kind;
    logic                     flit_last;
    logic [15:0]              pkt_count;
    logic [7:0]               err_count;

    int checks = 0;
    int errors = 0;

`ifdef ROUTER_SINK_ERR_EN
    localparam logic [7:0] EXP_ERR3 = 8'd3;
`else
    localparam logic [7:0] EXP_ERR3 = 8'd0;
`endif

    router_sink #(
        .FLIT_WIDTH   (16),
        .BUFFER_DEPTH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .data_in    (data_in),
        .credit_o   (credit_o),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .flit_out   (flit_out),
        .flit_kind  (flit_kind),
        .flit_last  (flit_last),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one flit for one edge, then release rx.
    task automatic drive_flit(input logic [15:0] d);
        rx      = 1'b1;
        data_in = d;
        @(posedge clock);
        #1;
        rx      = 1'b0;
    endtask

    task automatic do_reset();
        rx         = 1'b0;
        data_in    = '0;
        flit_ready = 1'b0;
        reset      = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset      = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        rx         = 1'b0;
        data_in    = '0;
        flit_ready = 1'b0;
        #3;
        checks++;
        if ({credit_o, flit_valid, flit_out, flit_kind, flit_last} !== {1'b1, 1'b0, 16'h0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got cr=%b v=%b out=%h k=%0d l=%b, want cr=1 v=0 out=0000 k=0 l=0",
                     credit_o, flit_valid, flit_out, flit_kind, flit_last);
        end
        checks++;
        if (pkt_count !== 16'd0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: got pkt=%0d err=%0d, want 0 0", pkt_count, err_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] d [5];
        logic [1:0]  k [5];
        logic        l [5];
        d = '{16'h0011, 16'd3, 16'h000A, 16'h000B, 16'h000C};
        k = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
        l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        flit_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_flit(d[i]);
            checks++;
            if (flit_valid !== 1'b1 || flit_out !== d[i] || flit_kind !== k[i] || flit_last !== l[i]) begin
                errors++;
                $display("FAIL basic_flit%0d: got v=%b out=%h k=%0d l=%b, want v=1 out=%h k=%0d l=%b",
                         i, flit_valid, flit_out, flit_kind, flit_last, d[i], k[i], l[i]);
            end
        end
        @(posedge clock);
        #1;
        checks++;
        if (pkt_count !== 16'd1 || flit_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pkt: got pkt=%0d v=%b, want pkt=1 v=0", pkt_count, flit_valid);
        end
    endtask

    task automatic test_size_zero();
        do_reset();
        flit_ready = 1'b1;
        drive_flit(16'h0022);
        drive_flit(16'h0000);
        checks++;
        if (flit_kind !== 2'd1 || flit_last !== 1'b1 || flit_out !== 16'h0000) begin
            errors++;
            $display("FAIL size0_size: got k=%0d l=%b out=%h, want k=1 l=1 out=0000", flit_kind, flit_last, flit_out);
        end
        drive_flit(16'h0033);
        checks++;
        if (flit_kind !== 2'd0 || flit_last !== 1'b0 || flit_out !== 16'h0033) begin
            errors++;
            $display("FAIL size0_next: got k=%0d l=%b out=%h, want k=0 l=0 out=0033", flit_kind, flit_last, flit_out);
        end
        checks++;
        if (pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL size0_pkt: got %0d, want 1", pkt_count);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d [6];
        logic [1:0]  k [6];
        int idx  = 0;
        int got  = 0;
        logic acc;
        logic released = 1'b0;
        d = '{16'h0044, 16'd4, 16'h0101, 16'h0102, 16'h0103, 16'h0104};
        k = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
        do_reset();
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            if (flit_valid && flit_ready) begin
                checks++;
                if (flit_out !== d[got] || flit_kind !== k[got] || flit_last !== (got == 5)) begin
                    errors++;
                    $display("FAIL bp_out%0d: got out=%h k=%0d l=%b, want out=%h k=%0d l=%b",
                             got, flit_out, flit_kind, flit_last, d[got], k[got], (got == 5));
                end
                got++;
            end
            if (idx < 6 && credit_o) begin
                rx = 1'b1; data_in = d[idx]; acc = 1'b1;
            end else begin
                rx = 1'b0; acc = 1'b0;
            end
            @(posedge clock);
            #1;
            if (acc) idx++;
            if (idx == 4 && !released) begin
                checks++;
                if (credit_o !== 1'b0 || flit_valid !== 1'b1 || flit_out !== 16'h0044) begin
                    errors++;
                    $display("FAIL bp_full: got cr=%b v=%b out=%h, want cr=0 v=1 out=0044", credit_o, flit_valid, flit_out);
                end
                released   = 1'b1;
                flit_ready = 1'b1;
            end
        end
        rx = 1'b0;
        checks++;
        if (got != 6 || idx != 6) begin
            errors++;
            $display("FAIL bp_count: got delivered=%0d sent=%0d, want 6 6", got, idx);
        end
        checks++;
        if (pkt_count !== 16'd1 || flit_valid !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL bp_end: got pkt=%0d v=%b err=%0d, want pkt=1 v=0 err=0", pkt_count, flit_valid, err_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d [7];
        logic [1:0]  k [7];
        logic        l [7];
        d = '{16'h0051, 16'd1, 16'h00AA, 16'h0052, 16'd2, 16'h00B1, 16'h00B2};
        k = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2};
        l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        flit_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_flit(d[i]);
            checks++;
            if (flit_valid !== 1'b1 || flit_out !== d[i] || flit_kind !== k[i] || flit_last !== l[i]) begin
                errors++;
                $display("FAIL b2b_flit%0d: got v=%b out=%h k=%0d l=%b, want v=1 out=%h k=%0d l=%b",
                         i, flit_valid, flit_out, flit_kind, flit_last, d[i], k[i], l[i]);
            end
            if (i == 3) begin
                checks++;
                if (pkt_count !== 16'd1) begin
                    errors++;
                    $display("FAIL b2b_mid_pkt: got %0d, want 1", pkt_count);
                end
            end
        end
        @(posedge clock);
        #1;
        checks++;
        if (pkt_count !== 16'd2) begin
            errors++;
            $display("FAIL b2b_pkt: got %0d, want 2", pkt_count);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive_flit(16'h0061);
        drive_flit(16'd5);
        checks++;
        if (flit_valid !== 1'b1 || flit_out !== 16'h0061) begin
            errors++;
            $display("FAIL rstmid_pre: got v=%b out=%h, want v=1 out=0061", flit_valid, flit_out);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({credit_o, flit_valid, flit_out, flit_kind, flit_last} !== {1'b1, 1'b0, 16'h0, 2'd0, 1'b0} || pkt_count !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_async: got cr=%b v=%b out=%h k=%0d l=%b pkt=%0d, want 1 0 0000 0 0 0",
                     credit_o, flit_valid, flit_out, flit_kind, flit_last, pkt_count);
        end
        @(posedge clock);
        #1;
        reset      = 1'b0;
        flit_ready = 1'b1;
        drive_flit(16'h0071);
        checks++;
        if (flit_kind !== 2'd0 || flit_out !== 16'h0071 || flit_last !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_hdr: got k=%0d out=%h l=%b, want k=0 out=0071 l=0", flit_kind, flit_out, flit_last);
        end
        drive_flit(16'h0000);
        checks++;
        if (flit_kind !== 2'd1 || flit_last !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_size: got k=%0d l=%b, want k=1 l=1", flit_kind, flit_last);
        end
        @(posedge clock);
        #1;
        checks++;
        if (pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_pkt: got %0d, want 1", pkt_count);
        end
    endtask

    task automatic test_drop();
        logic [15:0] d [4];
        logic [1:0]  k [4];
        d = '{16'h0081, 16'd2, 16'h0001, 16'h0002};
        k = '{2'd0, 2'd1, 2'd2, 2'd2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_flit(d[i]);
        end
        checks++;
        if (credit_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_full: got credit=%b, want 0", credit_o);
        end
        rx      = 1'b1;
        data_in = 16'hDEAD;
        repeat (3) @(posedge clock);
        #1;
        rx = 1'b0;
        checks++;
        if (err_count !== EXP_ERR3) begin
            errors++;
            $display("FAIL drop_err: got %0d, want %0d", err_count, EXP_ERR3);
        end
        flit_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (flit_valid !== 1'b1 || flit_out !== d[i] || flit_kind !== k[i] || flit_last !== (i == 3)) begin
                errors++;
                $display("FAIL drop_drain%0d: got v=%b out=%h k=%0d l=%b, want v=1 out=%h k=%0d l=%b",
                         i, flit_valid, flit_out, flit_kind, flit_last, d[i], k[i], (i == 3));
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if (flit_valid !== 1'b0 || pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL drop_empty: got v=%b pkt=%0d, want v=0 pkt=1", flit_valid, pkt_count);
        end
        drive_flit(16'h0090);
        checks++;
        if (flit_kind !== 2'd0 || flit_out !== 16'h0090) begin
            errors++;
            $display("FAIL drop_frame: got k=%0d out=%h, want k=0 out=0090", flit_kind, flit_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_size_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_packet();
        test_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
